dm_bytelane: RTL and testbench

Parametrised data memory for the MIPS datapath with byte/halfword/word stores, sign- or zero-extending sub-word loads, alignment and range checking, and a sticky fault record. Sits in the MEM stage in place of the word-only data memory and serves `sw/sh/sb/lw/lh/lhu/lb/lbu`. Storage is `2**ADDR_WIDTH` 32-bit words, little-endian byte lanes.

---
 rtl/dm_bytelane.sv | 129 ++++++++++++
 tb/tb_dm_bytelane.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bytelane.sv
// Byte-lane data memory for the MEM stage: word/half/byte stores, extending loads,
// alignment/range/op checking and a sticky first-fault record. Optional store log: DM_WRITE_LOG_EN.
module dm_bytelane #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [2:0]  MemOp,
  input  logic [31:0] PC,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        fault,
  output logic        faultSticky,
  output logic [31:0] faultPC,
  output logic [31:0] faultAddr
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    OP_WORD  = 3'b000,
    OP_HALFU = 3'b001,
    OP_HALFS = 3'b010,
    OP_BYTEU = 3'b011,
    OP_BYTES = 3'b100
  } mem_op_e;

  logic [31:0]           mem_q [DEPTH];
  mem_op_e               op;
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  illegal_op;
  logic [31:0]           word_rd;
  logic [31:0]           word_wr;
  logic [15:0]           half_rd;
  logic [7:0]            byte_rd;
  logic                  wr_en;

  logic                  fault_sticky_q, fault_sticky_d;
  logic [31:0]           fault_pc_q, fault_pc_d;
  logic [31:0]           fault_addr_q, fault_addr_d;

  always_comb begin
    op           = mem_op_e'(MemOp);
    off          = addr - BASE_ADDR;
    idx          = off[ADDR_WIDTH+1:2];
    lane         = off[1:0];
    // Addresses below BASE_ADDR wrap to a huge offset and land here too.
    out_of_range = |off[31:ADDR_WIDTH+2];
    illegal_op   = (MemOp >= 3'b101);
    misaligned   = 1'b0;
    case (op)
      OP_WORD:            misaligned = |lane;
      OP_HALFU, OP_HALFS: misaligned = lane[0];
      default:            misaligned = 1'b0;
    endcase
    fault = (MemWrite | MemRead) & (out_of_range | misaligned | illegal_op);

    word_rd = mem_q[idx];
    half_rd = word_rd[{lane[1], 4'b0000} +: 16];
    byte_rd = word_rd[{lane, 3'b000} +: 8];

    word_wr = word_rd;
    case (op)
      OP_WORD:            word_wr = writeData;
      OP_HALFU, OP_HALFS: word_wr[{lane[1], 4'b0000} +: 16] = writeData[15:0];
      OP_BYTEU, OP_BYTES: word_wr[{lane, 3'b000} +: 8] = writeData[7:0];
      default:            word_wr = word_rd;
    endcase
    wr_en = MemWrite & ~fault & ~reset;

    readData = '0;
    if (MemRead && !fault) begin
      case (op)
        OP_WORD:  readData = word_rd;
        OP_HALFU: readData = {16'h0000, half_rd};
        OP_HALFS: readData = {{16{half_rd[15]}}, half_rd};
        OP_BYTEU: readData = {24'h000000, byte_rd};
        OP_BYTES: readData = {{24{byte_rd[7]}}, byte_rd};
        default:  readData = '0;
      endcase
    end

    fault_sticky_d = fault_sticky_q;
    fault_pc_d     = fault_pc_q;
    fault_addr_d   = fault_addr_q;
    if (fault && !fault_sticky_q) begin
      fault_sticky_d = 1'b1;
      fault_pc_d     = PC;
      fault_addr_d   = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      fault_sticky_q <= 1'b0;
      fault_pc_q     <= '0;
      fault_addr_q   <= '0;
    end else begin
      if (wr_en) mem_q[idx] <= word_wr;
      fault_sticky_q <= fault_sticky_d;
      fault_pc_q     <= fault_pc_d;
      fault_addr_q   <= fault_addr_d;
    end
  end

  assign faultSticky = fault_sticky_q;
  assign faultPC     = fault_pc_q;
  assign faultAddr   = fault_addr_q;

`ifdef DM_WRITE_LOG_EN
  logic [31:0] log_addr;
  always_comb log_addr = BASE_ADDR + (32'(idx) << 2);

  always_ff @(posedge clk) begin
    if (wr_en) $display("@%h: *%h <= %h", PC, log_addr, word_wr);
  end
`else
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// Randomised self-checking bench for dm_bytelane against a byte-array reference model,
// plus directed literal checks of the documented load/store/fault scenarios.
module tb_dm_bytelane;

  localparam int unsigned AW   = 6;
  localparam int unsigned NB   = 4 * (2 ** AW);
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite, MemRead;
  logic [2:0]  MemOp;
  logic [31:0] PC, addr, writeData;
  logic [31:0] readData;
  logic        fault, faultSticky;
  logic [31:0] faultPC, faultAddr;

  int checks   = 0;
  int failures = 0;

  dm_bytelane #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemOp(MemOp), .PC(PC), .addr(addr), .writeData(writeData),
    .readData(readData), .fault(fault), .faultSticky(faultSticky),
    .faultPC(faultPC), .faultAddr(faultAddr)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a flat little-endian byte array.
  logic [7:0]  mb [NB];
  logic        m_sticky;
  logic [31:0] m_pc, m_addr;

  function automatic int unsigned op_size(input logic [2:0] op);
    if (op == 3'd0) return 4;
    if (op <= 3'd2) return 2;
    return 1;
  endfunction

  function automatic logic m_fault(input logic we, input logic re,
                                   input logic [2:0] op, input logic [31:0] a);
    logic [31:0] o;
    logic bad;
    o   = a - BASE;
    bad = (o >= NB) || (op >= 3'd5) || (o % op_size(op) != 0);
    return (we | re) & bad;
  endfunction

  function automatic logic [31:0] m_read(input logic re, input logic [2:0] op,
                                         input logic [31:0] a);
    logic [31:0] o;
    logic [15:0] h;
    if (!re || m_fault(1'b0, re, op, a)) return 32'h0;
    o = a - BASE;
    h = {mb[o+1], mb[o]};
    case (op)
      3'd0:    return {mb[o+3], mb[o+2], mb[o+1], mb[o]};
      3'd1:    return {16'h0, h};
      3'd2:    return {{16{h[15]}}, h};
      3'd3:    return {24'h0, mb[o]};
      default: return {{24{mb[o][7]}}, mb[o]};
    endcase
  endfunction

  always @(posedge clk) begin
    logic f;
    logic [31:0] o;
    if (reset) begin
      for (int i = 0; i < NB; i++) mb[i] = 8'h00;
      m_sticky = 1'b0;
      m_pc     = 32'h0;
      m_addr   = 32'h0;
    end else begin
      f = m_fault(MemWrite, MemRead, MemOp, addr);
      if (f && !m_sticky) begin
        m_sticky = 1'b1;
        m_pc     = PC;
        m_addr   = addr;
      end
      if (MemWrite && !f) begin
        o = addr - BASE;
        for (int k = 0; k < int'(op_size(MemOp)); k++) mb[o+k] = writeData[8*k +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    chk("cyc_readData", readData, m_read(MemRead, MemOp, addr));
    chk("cyc_fault", {31'h0, fault}, {31'h0, m_fault(MemWrite, MemRead, MemOp, addr)});
    chk("cyc_sticky", {31'h0, faultSticky}, {31'h0, m_sticky});
    chk("cyc_faultPC", faultPC, m_pc);
    chk("cyc_faultAddr", faultAddr, m_addr);
  end

  task automatic drive(input logic we, input logic re, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
    MemWrite = we; MemRead = re; MemOp = op; addr = a; writeData = wd; PC = pc;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    reset = 1'b1;
    drive(1'b0, 1'b0, 3'd0, BASE, 32'h0, 32'h0);
    tick;
    reset = 1'b0;
    #1;
    chk("rst_readData", readData, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    chk("rst_sticky", {31'h0, faultSticky}, 32'h0);
    chk("rst_faultPC", faultPC, 32'h0);

    drive(1'b1, 1'b0, 3'd0, BASE + 32'h10, 32'h1234_5678, 32'h3000); tick;
    drive(1'b0, 1'b1, 3'd0, BASE + 32'h10, 32'h0, 32'h3000); #1;
    chk("lw_10", readData, 32'h1234_5678);
    chk("lw_10_fault", {31'h0, fault}, 32'h0);
    chk("model_lw_10", m_read(1'b1, 3'd0, BASE + 32'h10), 32'h1234_5678);
    tick;

    drive(1'b1, 1'b0, 3'd3, BASE + 32'h11, 32'hFFFF_FFAB, 32'h3008); tick;
    drive(1'b1, 1'b0, 3'd1, BASE + 32'h12, 32'h1111_BEEF, 32'h300C); tick;
    drive(1'b0, 1'b1, 3'd0, BASE + 32'h10, 32'h0, 32'h3010); #1;
    chk("lw_merged", readData, 32'hBEEF_AB78);
    drive(1'b0, 1'b1, 3'd4, BASE + 32'h11, 32'h0, 32'h3010); #1;
    chk("lb_11", readData, 32'hFFFF_FFAB);
    drive(1'b0, 1'b1, 3'd3, BASE + 32'h11, 32'h0, 32'h3010); #1;
    chk("lbu_11", readData, 32'h0000_00AB);
    drive(1'b0, 1'b1, 3'd2, BASE + 32'h12, 32'h0, 32'h3010); #1;
    chk("lh_12", readData, 32'hFFFF_BEEF);
    chk("model_lh_12", m_read(1'b1, 3'd2, BASE + 32'h12), 32'hFFFF_BEEF);
    tick;

    drive(1'b1, 1'b0, 3'd0, BASE + 32'h2, 32'hFFFF_FFFF, 32'h3004); #1;
    chk("sw_mis_fault", {31'h0, fault}, 32'h1);
    chk("sw_mis_sticky_pre", {31'h0, faultSticky}, 32'h0);
    tick;
    drive(1'b0, 1'b1, 3'd0, BASE, 32'h0, 32'h3014); #1;
    chk("sw_mis_sticky", {31'h0, faultSticky}, 32'h1);
    chk("sw_mis_faultPC", faultPC, 32'h3004);
    chk("sw_mis_faultAddr", faultAddr, BASE + 32'h2);
    chk("sw_mis_nowrite", readData, 32'h0);
    tick;
    drive(1'b0, 1'b1, 3'd2, BASE + 32'h1, 32'h0, 32'h4000); #1;
    chk("lh_mis_fault", {31'h0, fault}, 32'h1);
    chk("lh_mis_readData", readData, 32'h0);
    tick;
    drive(1'b0, 1'b0, 3'd0, BASE, 32'h0, 32'h0); #1;
    chk("record_kept_PC", faultPC, 32'h3004);
    chk("record_kept_addr", faultAddr, BASE + 32'h2);

    drive(1'b1, 1'b0, 3'd0, BASE + NB, 32'hDEAD_BEEF, 32'h5000); #1;
    chk("sw_oor_fault", {31'h0, fault}, 32'h1);
    tick;
    drive(1'b0, 1'b1, 3'd0, BASE - 32'h4, 32'h0, 32'h5004); #1;
    chk("lw_wrap_fault", {31'h0, fault}, 32'h1);
    chk("lw_wrap_readData", readData, 32'h0);
    drive(1'b0, 1'b1, 3'd0, BASE, 32'h0, 32'h5008); #1;
    chk("oor_nowrite", readData, 32'h0);
    drive(1'b0, 1'b1, 3'd7, BASE, 32'h0, 32'h5008); #1;
    chk("illegal_op_fault", {31'h0, fault}, 32'h1);
    tick;

    drive(1'b1, 1'b0, 3'd0, BASE + 32'h20, 32'h0000_0001, 32'h6000); tick;
    drive(1'b1, 1'b1, 3'd0, BASE + 32'h20, 32'hCAFE_F00D, 32'h6004); #1;
    chk("rmw_pre", readData, 32'h0000_0001);
    tick;
    drive(1'b0, 1'b1, 3'd0, BASE + 32'h20, 32'h0, 32'h6008); #1;
    chk("rmw_post", readData, 32'hCAFE_F00D);
    tick;

    reset = 1'b1;
    drive(1'b1, 1'b0, 3'd0, BASE + 32'h24, 32'h5555_5555, 32'h7000);
    tick;
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'd0, BASE, 32'h0, 32'h0); #1;
    chk("rst2_sticky", {31'h0, faultSticky}, 32'h0);
    chk("rst2_faultPC", faultPC, 32'h0);
    chk("rst2_faultAddr", faultAddr, 32'h0);
    for (int w = 0; w < NB / 4; w++) begin
      drive(1'b0, 1'b1, 3'd0, BASE + 32'(4 * w), 32'h0, 32'h0); #1;
      chk("rst2_word", readData, 32'h0);
    end
    tick;

    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 19);
      if (r == 0)      a = BASE - 32'($urandom_range(1, 16));
      else if (r == 1) a = BASE + NB + 32'($urandom_range(0, 15));
      else             a = BASE + 32'($urandom_range(0, NB - 1));
      if (r >= 2 && r < 10) a[1:0] = 2'b00;
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
            a, $urandom, $urandom);
      tick;
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'd0, BASE, 32'h0, 32'h0);
    tick;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
